dp_controller: RTL

Multi-cycle sequencer for ARM data-processing instructions: it is the instruction-facing side of the ALU interface, producing `ALUControl`, `SrcA` and `SrcB` and consuming `ALUResult`. It accepts one 32-bit instruction per valid/ready handshake and decodes it. It evaluates the condition field against its own N/Z flags, reads operands from an internal 16×32 register file, drives the ALU for one cycle, and writes the result back. It sits between the instruction source (fetch stage or testbench) and the combinational ALU.

---
 rtl/dp_pkg.sv | 51 +++++
 rtl/dp_regfile.sv | 40 ++++
 rtl/dp_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared types and encodings for the data-processing instruction sequencer.
package dp_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned REG_AW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic        imm;
    logic [3:0]  cmd;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] op2;
  } instr_t;

  // imm8 rotated right by twice the 4-bit rotate field
  function automatic logic [XLEN-1:0] rot_imm(input logic [11:0] op2);
    logic [2*XLEN-1:0] dbl;
    dbl = {2{24'd0, op2[7:0]}};
    dbl = dbl >> {op2[11:8], 1'b0};
    return dbl[XLEN-1:0];
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// 16-entry register file: one write port, operand and debug read ports.
module dp_regfile
  import dp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [REG_AW-1:0]     raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [REG_AW-1:0]     raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic [REG_AW-1:0]     raddr_dbg,
  output logic [DATA_WIDTH-1:0] rdata_dbg
);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a   = regs_q[raddr_a];
  assign rdata_b   = regs_q[raddr_b];
  assign rdata_dbg = regs_q[raddr_dbg];

endmodule

// File: rtl/dp_controller.sv
// Multi-cycle sequencer for data-processing instructions: decode, condition
// check, ALU drive for one cycle, then register/flag writeback.
module dp_controller
  import dp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  InstrValid,
  output logic                  InstrReady,
  input  logic [31:0]           Instr,
  output logic [3:0]            ALUControl,
  output logic [DATA_WIDTH-1:0] SrcA,
  output logic [DATA_WIDTH-1:0] SrcB,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Done,
  output logic                  Undef,
  output logic [1:0]            Flags,
  input  logic [3:0]            DbgAddr,
  output logic [DATA_WIDTH-1:0] DbgData
);

  state_e                state_q, state_d;
  instr_t                instr_q, instr_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [1:0]            flags_q, flags_d;
  logic                  exec_q, exec_d;
  logic                  undef_q, undef_d;
  logic                  done_q, done_d;
  logic                  undef_out_q, undef_out_d;
  logic                  ready_q, ready_d;

  logic                  wr_en_c;
  logic                  undef_c;
  logic                  cond_pass_c;
  logic [3:0]            alu_ctrl_c;
  logic [DATA_WIDTH-1:0] rn_data_c, rm_data_c;

  dp_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk       (clk),
    .rst_n     (reset_n),
    .we        (wr_en_c),
    .waddr     (instr_q.rd),
    .wdata     (result_q),
    .raddr_a   (instr_q.rn),
    .rdata_a   (rn_data_c),
    .raddr_b   (instr_q.op2[3:0]),
    .rdata_b   (rm_data_c),
    .raddr_dbg (DbgAddr),
    .rdata_dbg (DbgData)
  );

  // Decode of the latched instruction: legality and condition outcome
  always_comb begin
    logic cmd_ok;
    logic cond_ok;
    cmd_ok      = 1'b0;
    cond_ok     = 1'b1;
    cond_pass_c = 1'b0;
    alu_ctrl_c  = instr_q.cmd;
    case (instr_q.cmd)
      CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR: cmd_ok = 1'b1;
      CMD_CMP: begin
        cmd_ok     = 1'b1;
        alu_ctrl_c = ALU_SUB;
      end
      default: cmd_ok = 1'b0;
    endcase
    case (instr_q.cond)
      COND_EQ: cond_pass_c = flags_q[0];
      COND_NE: cond_pass_c = !flags_q[0];
      COND_MI: cond_pass_c = flags_q[1];
      COND_PL: cond_pass_c = !flags_q[1];
      COND_AL: cond_pass_c = 1'b1;
      default: cond_ok     = 1'b0;
    endcase
    undef_c = (instr_q.op != 2'b00) || !cmd_ok || !cond_ok ||
              (!instr_q.imm && (instr_q.op2[11:4] != 8'd0));
  end

  // Next-state and writeback control
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    result_d    = result_q;
    flags_d     = flags_q;
    exec_d      = exec_q;
    undef_d     = undef_q;
    wr_en_c     = 1'b0;
    done_d      = 1'b0;
    undef_out_d = 1'b0;
    ready_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (InstrValid && ready_q) begin
          instr_d = Instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        undef_d = undef_c;
        exec_d  = !undef_c && cond_pass_c;
        state_d = (!undef_c && cond_pass_c) ? ST_EXEC : ST_WB;
      end
      ST_EXEC: begin
        result_d = ALUResult;
        state_d  = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        if (exec_q) begin
          wr_en_c = (instr_q.cmd != CMD_CMP);
          if (instr_q.s || (instr_q.cmd == CMD_CMP))
            flags_d = {result_q[DATA_WIDTH-1], result_q == '0};
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d      = (state_d == ST_WB);
    undef_out_d = (state_d == ST_WB) && undef_d;
    ready_d     = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      result_q    <= '0;
      flags_q     <= 2'b00;
      exec_q      <= 1'b0;
      undef_q     <= 1'b0;
      done_q      <= 1'b0;
      undef_out_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      exec_q      <= exec_d;
      undef_q     <= undef_d;
      done_q      <= done_d;
      undef_out_q <= undef_out_d;
      ready_q     <= ready_d;
    end
  end

  // ALU interface is only live during EXEC
  always_comb begin
    ALUControl = 4'd0;
    SrcA       = '0;
    SrcB       = '0;
    if (state_q == ST_EXEC) begin
      ALUControl = alu_ctrl_c;
      SrcA       = rn_data_c;
      SrcB       = instr_q.imm ? DATA_WIDTH'(rot_imm(instr_q.op2)) : rm_data_c;
    end
  end

  assign InstrReady = ready_q;
  assign Done       = done_q;
  assign Undef      = undef_out_q;
  assign Flags      = flags_q;

endmodule
